// File: rtl/pll_lock_ctrl.sv
// rtl/pll_lock_ctrl.sv - PLL reset/lock sequencer with lock qualification, retry, fail and loss tracking
module pll_lock_ctrl #(
  parameter int RST_CYCLES    = 100,
  parameter int LOCK_STABLE   = 1024,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int MAX_RETRY     = 3,
  parameter int RELEASE_DELAY = 16
) (
  input  logic       clkin1,
  input  logic       rst,
  input  logic       restart,
  input  logic       pll_lock_in,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       locked_ok,
  output logic       fail,
  output logic [2:0] state,
  output logic [3:0] retry_cnt,
  output logic [7:0] loss_cnt
);

  localparam int PM_A      = (RST_CYCLES > RELEASE_DELAY) ? RST_CYCLES : RELEASE_DELAY;
  localparam int PHASE_MAX = (PM_A > LOCK_TIMEOUT) ? PM_A : LOCK_TIMEOUT;
  localparam int PW        = $clog2(PHASE_MAX + 1);
  localparam int SW        = $clog2(LOCK_STABLE + 1);

  localparam logic [PW-1:0] RST_LAST    = PW'(RST_CYCLES - 1);
  localparam logic [PW-1:0] TMO_LAST    = PW'(LOCK_TIMEOUT - 1);
  localparam logic [PW-1:0] REL_LAST    = PW'(RELEASE_DELAY - 1);
  localparam logic [SW-1:0] STABLE_LAST = SW'(LOCK_STABLE - 1);
  localparam logic [3:0]    RETRY_MAX   = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    ST_RST_PLL   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_RELEASE   = 3'd2,
    ST_LOCKED    = 3'd3,
    ST_FAIL      = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [SW-1:0] stable_q, stable_d;
  logic [3:0]    retry_q, retry_d;
  logic [7:0]    loss_q, loss_d;
  logic          lock_meta_q, lock_s_q;
  logic          pll_rst_q, sys_rst_q, locked_ok_q, fail_q;

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    stable_d = stable_q;
    retry_d  = retry_q;
    loss_d   = loss_q;
    case (state_q)
      ST_RST_PLL: begin
        phase_d = phase_q + PW'(1);
        if (phase_q == RST_LAST) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        // phase_q doubles as the per-attempt timeout counter here
        phase_d  = phase_q + PW'(1);
        stable_d = lock_s_q ? stable_q + SW'(1) : '0;
        if (lock_s_q && (stable_q == STABLE_LAST)) begin
          state_d = ST_RELEASE;
        end else if (phase_q == TMO_LAST) begin
          if (retry_q == RETRY_MAX) begin
            state_d = ST_FAIL;
          end else begin
            retry_d = retry_q + 4'd1;
            state_d = ST_RST_PLL;
          end
        end
      end
      ST_RELEASE: begin
        phase_d = phase_q + PW'(1);
        if (!lock_s_q) begin
          state_d = ST_WAIT_LOCK;
        end else if (phase_q == REL_LAST) begin
          state_d = ST_LOCKED;
          retry_d = '0;
        end
      end
      ST_LOCKED: begin
        if (!lock_s_q) begin
          state_d = ST_RST_PLL;
          if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
        end
      end
      ST_FAIL: begin
        state_d = ST_FAIL;
      end
      default: state_d = ST_RST_PLL;
    endcase
    if (restart) begin
      state_d = ST_RST_PLL;
      retry_d = '0;
      loss_d  = loss_q;
    end
    if (restart || (state_d != state_q)) begin
      phase_d  = '0;
      stable_d = '0;
    end
  end

  always_ff @(posedge clkin1) begin
    if (rst) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
      state_q     <= ST_RST_PLL;
      phase_q     <= '0;
      stable_q    <= '0;
      retry_q     <= '0;
      loss_q      <= '0;
      pll_rst_q   <= 1'b1;
      sys_rst_q   <= 1'b1;
      locked_ok_q <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      lock_meta_q <= pll_lock_in;
      lock_s_q    <= lock_meta_q;
      state_q     <= state_d;
      phase_q     <= phase_d;
      stable_q    <= stable_d;
      retry_q     <= retry_d;
      loss_q      <= loss_d;
      // outputs decode the next state so they change together with state
      pll_rst_q   <= (state_d == ST_RST_PLL) || (state_d == ST_FAIL);
      sys_rst_q   <= (state_d != ST_LOCKED);
      locked_ok_q <= (state_d == ST_LOCKED);
      fail_q      <= (state_d == ST_FAIL);
    end
  end

  assign pll_rst   = pll_rst_q;
  assign sys_rst   = sys_rst_q;
  assign locked_ok = locked_ok_q;
  assign fail      = fail_q;
  assign state     = state_q;
  assign retry_cnt = retry_q;
  assign loss_cnt  = loss_q;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// tb/tb_pll_lock_ctrl.sv - bench for pll_lock_ctrl: vector table, corner sequences, random vs model
module tb_pll_lock_ctrl;

  localparam int RST_CYCLES    = 4;
  localparam int LOCK_STABLE   = 8;
  localparam int LOCK_TIMEOUT  = 32;
  localparam int MAX_RETRY     = 2;
  localparam int RELEASE_DELAY = 4;

  localparam int M_RST = 0, M_WAIT = 1, M_REL = 2, M_LOCKED = 3, M_FAIL = 4;

  logic       clk = 1'b0;
  logic       rst_r = 1'b1, restart_r = 1'b0, lock_r = 1'b0;
  logic       pll_rst, sys_rst, locked_ok, fail;
  logic [2:0] state;
  logic [3:0] retry_cnt;
  logic [7:0] loss_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  pll_lock_ctrl #(
    .RST_CYCLES(RST_CYCLES), .LOCK_STABLE(LOCK_STABLE), .LOCK_TIMEOUT(LOCK_TIMEOUT),
    .MAX_RETRY(MAX_RETRY), .RELEASE_DELAY(RELEASE_DELAY)
  ) dut (
    .clkin1(clk), .rst(rst_r), .restart(restart_r), .pll_lock_in(lock_r),
    .pll_rst(pll_rst), .sys_rst(sys_rst), .locked_ok(locked_ok), .fail(fail),
    .state(state), .retry_cnt(retry_cnt), .loss_cnt(loss_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: time-stamp based, tracks when the current phase began and
  // when lock was last seen low, and derives every decision from elapsed time.
  int     m_mode, m_retry, m_loss;
  longint now_t, entry_t, last_low_t;
  bit     m_s1, m_s2;

  task automatic model_edge(input bit r, input bit rs, input bit li);
    int     nxt;
    longint age, run;
    bit     ls;
    now_t++;
    if (r) begin
      m_mode = M_RST; m_retry = 0; m_loss = 0;
      entry_t = now_t; last_low_t = now_t - 1;
      m_s1 = 0; m_s2 = 0;
      return;
    end
    ls  = m_s2;
    age = now_t - entry_t;
    nxt = m_mode;
    if (rs) begin
      nxt = M_RST;
      m_retry = 0;
    end else begin
      case (m_mode)
        M_RST: if (age >= RST_CYCLES) nxt = M_WAIT;
        M_WAIT: begin
          if (!ls) last_low_t = now_t - 1;
          run = (now_t - 1) - last_low_t;
          if (ls && run >= LOCK_STABLE) nxt = M_REL;
          else if (age >= LOCK_TIMEOUT) begin
            if (m_retry == MAX_RETRY) nxt = M_FAIL;
            else begin m_retry++; nxt = M_RST; end
          end
        end
        M_REL: begin
          if (!ls) nxt = M_WAIT;
          else if (age >= RELEASE_DELAY) begin nxt = M_LOCKED; m_retry = 0; end
        end
        M_LOCKED: if (!ls) begin
          nxt = M_RST;
          if (m_loss < 255) m_loss++;
        end
        default: nxt = m_mode;
      endcase
    end
    if (rs || nxt != m_mode) begin
      entry_t = now_t; last_low_t = now_t - 1;
    end
    m_mode = nxt;
    m_s2 = m_s1;
    m_s1 = li;
  endtask

  function automatic logic [18:0] pack(input int st, input bit p, input bit s, input bit lo,
                                       input bit f, input int rc, input int lc);
    pack = {3'(st), p, s, lo, f, 4'(rc), 8'(lc)};
  endfunction

  function automatic logic [18:0] model_pack();
    model_pack = pack(m_mode, (m_mode == M_RST) || (m_mode == M_FAIL), m_mode != M_LOCKED,
                      m_mode == M_LOCKED, m_mode == M_FAIL, m_retry, m_loss);
  endfunction

  function automatic logic [18:0] dut_pack();
    dut_pack = {state, pll_rst, sys_rst, locked_ok, fail, retry_cnt, loss_cnt};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %05h want %05h (state|pll_rst|sys_rst|locked_ok|fail|retry|loss)",
               name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_edge(rst_r, restart_r, lock_r);
    check($sformatf("model t=%0d", now_t), 32'(dut_pack()), 32'(model_pack()));
  endtask

  task automatic wait_locked(output bit ok);
    ok = 0;
    for (int i = 0; i < 64; i++) begin
      if (locked_ok === 1'b1) begin ok = 1; return; end
      tick();
    end
  endtask

  typedef struct {
    bit          rst;
    bit          restart;
    bit          lock;
    int          ncyc;
    logic [18:0] exp;
  } vec_t;

  function automatic vec_t v(input bit r, input bit rs, input bit lk, input int n, input int st,
                             input bit p, input bit s, input bit lo, input bit f,
                             input int rc, input int lc);
    v.rst = r; v.restart = rs; v.lock = lk; v.ncyc = n;
    v.exp = pack(st, p, s, lo, f, rc, lc);
  endfunction

  vec_t vecs[21];

  initial begin
    bit ok;
    int hold;
    now_t = 0; entry_t = 0; last_low_t = -1;
    m_mode = M_RST; m_retry = 0; m_loss = 0; m_s1 = 0; m_s2 = 0;

    // rst, restart, lock, cycles, then expected state/pll/sys/locked/fail/retry/loss
    vecs[0]  = v(1, 0, 1,  3, 0, 1, 1, 0, 0, 0, 0);
    vecs[1]  = v(0, 0, 1,  3, 0, 1, 1, 0, 0, 0, 0);
    vecs[2]  = v(0, 0, 1,  1, 1, 0, 1, 0, 0, 0, 0);
    vecs[3]  = v(0, 0, 1, 11, 2, 0, 1, 0, 0, 0, 0);
    vecs[4]  = v(0, 0, 1,  1, 3, 0, 0, 1, 0, 0, 0);
    vecs[5]  = v(1, 0, 0,  2, 0, 1, 1, 0, 0, 0, 0);
    vecs[6]  = v(0, 0, 0, 35, 1, 0, 1, 0, 0, 0, 0);
    vecs[7]  = v(0, 0, 0,  1, 0, 1, 1, 0, 0, 1, 0);
    vecs[8]  = v(0, 0, 0, 36, 0, 1, 1, 0, 0, 2, 0);
    vecs[9]  = v(0, 0, 0, 35, 1, 0, 1, 0, 0, 2, 0);
    vecs[10] = v(0, 0, 0,  1, 4, 1, 1, 0, 1, 2, 0);
    vecs[11] = v(0, 0, 0, 20, 4, 1, 1, 0, 1, 2, 0);
    vecs[12] = v(0, 1, 1,  1, 0, 1, 1, 0, 0, 0, 0);
    vecs[13] = v(0, 0, 1, 15, 2, 0, 1, 0, 0, 0, 0);
    vecs[14] = v(0, 0, 1,  1, 3, 0, 0, 1, 0, 0, 0);
    vecs[15] = v(0, 0, 0,  1, 3, 0, 0, 1, 0, 0, 0);
    vecs[16] = v(0, 0, 1,  1, 3, 0, 0, 1, 0, 0, 0);
    vecs[17] = v(0, 0, 1,  1, 0, 1, 1, 0, 0, 0, 1);
    vecs[18] = v(0, 0, 1, 16, 3, 0, 0, 1, 0, 0, 1);
    vecs[19] = v(0, 1, 1,  1, 0, 1, 1, 0, 0, 0, 1);
    vecs[20] = v(0, 0, 1, 16, 3, 0, 0, 1, 0, 0, 1);

    for (int i = 0; i < 21; i++) begin
      rst_r = vecs[i].rst; restart_r = vecs[i].restart; lock_r = vecs[i].lock;
      repeat (vecs[i].ncyc) tick();
      check($sformatf("vec%0d", i), 32'(dut_pack()), 32'(vecs[i].exp));
    end
    restart_r = 0;

    // Glitch during qualification: lock_s high 7 cycles, low 1, then high.
    rst_r = 1; lock_r = 0; tick(); rst_r = 0;
    for (int j = 0; j < 20; j++) begin
      lock_r = ((j >= 2) && (j <= 8)) || (j >= 10);
      tick();
      if (j + 1 == 12) check("glitch_still_wait", 32'(state), 32'(1));
      if (j + 1 == 19) check("glitch_pre_release", 32'(state), 32'(1));
      if (j + 1 == 20) check("glitch_release", 32'(state), 32'(2));
    end
    check("glitch_loss", 32'(loss_cnt), 32'(0));

    // Lock-loss saturation: 260 losses.
    lock_r = 1;
    for (int n = 0; n < 260; n++) begin
      wait_locked(ok);
      if (!ok) begin check("sat_wait_locked", 32'(0), 32'(1)); break; end
      lock_r = 0; tick(); lock_r = 1; tick(); tick();
    end
    wait_locked(ok);
    check("sat_relock", 32'(ok), 32'(1));
    check("sat_loss255", 32'(loss_cnt), 32'(255));
    lock_r = 0; tick(); lock_r = 1; tick(); tick();
    check("sat_hold255", 32'(loss_cnt), 32'(255));

    // rst mid-RELEASE returns everything to reset values.
    ok = 0;
    for (int i = 0; i < 64; i++) begin
      if (state === 3'd2) begin ok = 1; break; end
      tick();
    end
    check("reach_release", 32'(ok), 32'(1));
    tick();
    rst_r = 1; tick();
    check("rst_mid_release", 32'(dut_pack()), 32'(pack(0, 1, 1, 0, 0, 0, 0)));
    rst_r = 0;

    // Randomized stimulus; every cycle is compared against the model inside tick().
    hold = 0;
    for (int c = 0; c < 4000; c++) begin
      if (hold == 0) begin
        lock_r = ($urandom_range(0, 3) != 0);
        hold = $urandom_range(1, 60);
      end
      hold--;
      restart_r = ($urandom_range(0, 149) == 0);
      rst_r = ($urandom_range(0, 599) == 0);
      tick();
      restart_r = 0; rst_r = 0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
